// File: rtl/fanout_pipe_tree.sv
// Pipelined, fanout-bounded distribution tree: one source word is copied
// to NUM_SINKS registered, maskable sinks with optional leaf inversion.
module fanout_pipe_tree #(
    parameter int WIDTH      = 1,
    parameter int NUM_SINKS  = 8,
    parameter int MAX_FANOUT = 4,
    parameter int INVERT     = 1,
    parameter int CNT_W      = 16
) (
    input  logic                       iccad_clk,
    input  logic                       iccad_rst,
    input  logic                       inp_valid,
    input  logic [WIDTH-1:0]           inp_data,
    input  logic [NUM_SINKS-1:0]       sink_mask,
    input  logic                       stall,
    output logic [NUM_SINKS-1:0]       out_valid,
    output logic [NUM_SINKS*WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]           xfer_count
);

    function automatic int calc_levels(input int n, input int f);
        int     l;
        longint p;
        l = 1;
        p = f;
        if (f < 2) return 1;
        while (p < n) begin
            p = p * f;
            l++;
        end
        return l;
    endfunction

    localparam int LEVELS = calc_levels(NUM_SINKS, MAX_FANOUT);

    function automatic int pow_i(input int b, input int e);
        int r;
        r = 1;
        for (int i = 0; i < e; i++) r = r * b;
        return r;
    endfunction

    function automatic int node_cnt(input int k);
        int p;
        p = pow_i(MAX_FANOUT, LEVELS - 1 - k);
        return (NUM_SINKS + p - 1) / p;
    endfunction

    function automatic int node_off(input int k);
        int s;
        s = 0;
        for (int i = 0; i < k; i++) s = s + node_cnt(i);
        return s;
    endfunction

    localparam int NI = node_off(LEVELS - 1);

    if (NUM_SINKS < 1 || MAX_FANOUT < 2 || LEVELS > 8) begin : g_bad_cfg
        $error("fanout_pipe_tree: illegal NUM_SINKS/MAX_FANOUT/LEVELS");
    end

    logic [NUM_SINKS-1:0]       leaf_v;
    logic [NUM_SINKS-1:0]       leaf_m;
    logic [NUM_SINKS*WIDTH-1:0] leaf_d;

    if (LEVELS == 1) begin : g_flat
        assign leaf_v = {NUM_SINKS{inp_valid}};
        assign leaf_d = {NUM_SINKS{inp_data}};
        assign leaf_m = sink_mask;
    end else begin : g_tree
        // Interior nodes of all non-leaf levels, packed level by level.
        logic [NI-1:0]        nv_q;
        logic [NI*WIDTH-1:0]  nd_q;
        logic [NUM_SINKS-1:0] mp_q [LEVELS-1];

        for (genvar k = 0; k < LEVELS - 1; k++) begin : g_lvl
            for (genvar j = 0; j < node_cnt(k); j++) begin : g_node
                localparam int IDX = node_off(k) + j;
                logic             src_v;
                logic [WIDTH-1:0] src_d;
                if (k == 0) begin : g_root
                    assign src_v = inp_valid;
                    assign src_d = inp_data;
                end else begin : g_inner
                    localparam int P = node_off(k - 1) + j / MAX_FANOUT;
                    assign src_v = nv_q[P];
                    assign src_d = nd_q[P*WIDTH +: WIDTH];
                end
                always_ff @(posedge iccad_clk or posedge iccad_rst) begin
                    if (iccad_rst) begin
                        nv_q[IDX]              <= 1'b0;
                        nd_q[IDX*WIDTH +: WIDTH] <= '0;
                    end else if (!stall) begin
                        nv_q[IDX]              <= src_v;
                        nd_q[IDX*WIDTH +: WIDTH] <= src_d;
                    end
                end
            end
        end

        always_ff @(posedge iccad_clk or posedge iccad_rst) begin
            if (iccad_rst) begin
                for (int s = 0; s < LEVELS - 1; s++) mp_q[s] <= '0;
            end else if (!stall) begin
                mp_q[0] <= sink_mask;
                for (int s = 1; s < LEVELS - 1; s++) mp_q[s] <= mp_q[s-1];
            end
        end

        for (genvar i = 0; i < NUM_SINKS; i++) begin : g_leaf_src
            localparam int P = node_off(LEVELS - 2) + i / MAX_FANOUT;
            assign leaf_v[i] = nv_q[P];
            assign leaf_d[i*WIDTH +: WIDTH] = nd_q[P*WIDTH +: WIDTH];
        end

        assign leaf_m = mp_q[LEVELS-2];
    end

    logic [NUM_SINKS-1:0]       out_valid_d, out_valid_q;
    logic [NUM_SINKS*WIDTH-1:0] out_data_d, out_data_q;
    logic [CNT_W-1:0]           cnt_d, cnt_q;

    // Unselected sinks keep their last word, like a clock-gated cell.
    always_comb begin
        out_valid_d = leaf_v & leaf_m;
        out_data_d  = out_data_q;
        for (int i = 0; i < NUM_SINKS; i++) begin
            if (out_valid_d[i]) begin
                out_data_d[i*WIDTH +: WIDTH] = (INVERT != 0) ?
                    ~leaf_d[i*WIDTH +: WIDTH] : leaf_d[i*WIDTH +: WIDTH];
            end
        end
        cnt_d = cnt_q;
        if ((|out_valid_d) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge iccad_clk or posedge iccad_rst) begin
        if (iccad_rst) begin
            out_valid_q <= '0;
            out_data_q  <= '0;
            cnt_q       <= '0;
        end else if (!stall) begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign xfer_count = cnt_q;

endmodule

// File: tb/tb_fanout_pipe_tree.sv
// Bench for fanout_pipe_tree: two configurations checked against a
// cycle-level reference model of delayed, masked, optionally inverted copies.
module tb_fanout_pipe_tree;

    logic clk;
    logic rst;

    logic        a_v, a_s;
    logic [0:0]  a_d;
    logic [7:0]  a_m;
    logic [7:0]  a_ov;
    logic [7:0]  a_od;
    logic [15:0] a_cnt;

    logic        b_v, b_s;
    logic [3:0]  b_d;
    logic [4:0]  b_m;
    logic [4:0]  b_ov;
    logic [19:0] b_od;
    logic [2:0]  b_cnt;

    int total = 0;
    int bad   = 0;

    fanout_pipe_tree #(
        .WIDTH(1), .NUM_SINKS(8), .MAX_FANOUT(4), .INVERT(1), .CNT_W(16)
    ) u_a (
        .iccad_clk(clk), .iccad_rst(rst),
        .inp_valid(a_v), .inp_data(a_d), .sink_mask(a_m), .stall(a_s),
        .out_valid(a_ov), .out_data(a_od), .xfer_count(a_cnt)
    );

    fanout_pipe_tree #(
        .WIDTH(4), .NUM_SINKS(5), .MAX_FANOUT(2), .INVERT(0), .CNT_W(3)
    ) u_b (
        .iccad_clk(clk), .iccad_rst(rst),
        .inp_valid(b_v), .inp_data(b_d), .sink_mask(b_m), .stall(b_s),
        .out_valid(b_ov), .out_data(b_od), .xfer_count(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: an accepted input reappears LEVELS accepted edges later.
    bit         pv [2][8];
    logic [7:0] pm [2][8];
    logic [3:0] pd [2][8];
    bit         ev [2][8];
    logic [3:0] ed [2][8];
    int         mc [2];

    task automatic model_reset();
        for (int x = 0; x < 2; x++) begin
            for (int k = 0; k < 8; k++) begin
                pv[x][k] = 0; pm[x][k] = '0; pd[x][k] = '0;
                ev[x][k] = 0; ed[x][k] = '0;
            end
            mc[x] = 0;
        end
    endtask

    task automatic model_edge(input int x);
        int lv, n, inv, cmax;
        bit v, s, any;
        logic [7:0] m;
        logic [3:0] d, wm;
        if (x == 0) begin
            lv = 2; n = 8; inv = 1; cmax = 65535; wm = 4'h1;
            v = a_v; s = a_s; m = a_m; d = {3'b000, a_d};
        end else begin
            lv = 3; n = 5; inv = 0; cmax = 7; wm = 4'hF;
            v = b_v; s = b_s; m = {3'b000, b_m}; d = b_d;
        end
        if (rst) begin
            model_reset();
            return;
        end
        if (s) return;
        for (int k = 7; k > 0; k--) begin
            pv[x][k] = pv[x][k-1]; pm[x][k] = pm[x][k-1]; pd[x][k] = pd[x][k-1];
        end
        pv[x][0] = v; pm[x][0] = m; pd[x][0] = d;
        any = 0;
        for (int i = 0; i < n; i++) begin
            if (pv[x][lv-1] && pm[x][lv-1][i]) begin
                ev[x][i] = 1;
                ed[x][i] = (inv != 0) ? (~pd[x][lv-1] & wm) : pd[x][lv-1];
                any = 1;
            end else begin
                ev[x][i] = 0;
            end
        end
        if (any && mc[x] < cmax) mc[x]++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [7:0]  eav, ead;
        logic [4:0]  ebv;
        logic [19:0] ebd;
        for (int i = 0; i < 8; i++) begin
            eav[i] = ev[0][i];
            ead[i] = ed[0][i][0];
        end
        for (int i = 0; i < 5; i++) begin
            ebv[i] = ev[1][i];
            ebd[i*4 +: 4] = ed[1][i];
        end
        chk("a_valid", 32'(a_ov), 32'(eav));
        chk("a_data", 32'(a_od), 32'(ead));
        chk("a_count", 32'(a_cnt), 32'(mc[0]));
        chk("b_valid", 32'(b_ov), 32'(ebv));
        chk("b_data", 32'(b_od), 32'(ebd));
        chk("b_count", 32'(b_cnt), 32'(mc[1]));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check_model();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] cnt0;
        rst = 1'b1;
        a_v = 0; a_s = 0; a_d = '0; a_m = '0;
        b_v = 0; b_s = 0; b_d = '0; b_m = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_valid", 32'(a_ov), 32'h0);
        chk("rst_a_data", 32'(a_od), 32'h0);
        chk("rst_a_count", 32'(a_cnt), 32'h0);
        chk("rst_b_valid", 32'(b_ov), 32'h0);
        chk("rst_b_data", 32'(b_od), 32'h0);
        chk("rst_b_count", 32'(b_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // single inverted broadcast, latency 2
        a_v = 1; a_d = 1'b1; a_m = 8'hFF;
        cyc();
        chk("t1_not_early", 32'(a_ov), 32'h0);
        a_v = 0;
        cyc();
        chk("t1_valid", 32'(a_ov), 32'hFF);
        chk("t1_data", 32'(a_od), 32'h00);
        cyc();
        chk("t1_valid_drop", 32'(a_ov), 32'h0);
        chk("t1_hold", 32'(a_od), 32'h00);
        chk("t1_count", 32'(a_cnt), 32'd1);

        // masking: unselected sinks hold the earlier word
        a_v = 1; a_d = 1'b0; a_m = 8'hFF;
        cyc();
        a_d = 1'b1; a_m = 8'h0F;
        cyc();
        chk("t3_first_valid", 32'(a_ov), 32'hFF);
        chk("t3_first_data", 32'(a_od), 32'hFF);
        a_v = 0; a_m = 8'h00;
        cyc();
        chk("t3_mask_valid", 32'(a_ov), 32'h0F);
        chk("t3_mask_data", 32'(a_od), 32'hF0);

        // stall freezes the pipe and discards inputs
        a_v = 1; a_d = 1'b1; a_m = 8'hFF;
        cyc();
        cnt0 = a_cnt;
        a_s = 1; a_d = 1'b0;
        repeat (3) begin
            cyc();
            chk("t4_stall_valid", 32'(a_ov), 32'h0);
            chk("t4_stall_count", 32'(a_cnt), 32'(cnt0));
        end
        a_s = 0; a_v = 0;
        cyc();
        chk("t4_late_valid", 32'(a_ov), 32'hFF);
        chk("t4_late_data", 32'(a_od), 32'h00);
        cyc();
        chk("t4_no_junk", 32'(a_ov), 32'h0);

        // async reset with transfers in flight
        a_v = 1; a_m = 8'hFF; b_v = 1; b_d = 4'h9; b_m = 5'h1F;
        cyc();
        cyc();
        a_v = 0; b_v = 0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("t5_a_valid", 32'(a_ov), 32'h0);
        chk("t5_a_data", 32'(a_od), 32'h0);
        chk("t5_b_data", 32'(b_od), 32'h0);
        chk("t5_b_count", 32'(b_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            cyc();
            chk("t5_quiet_b", 32'(b_ov), 32'h0);
        end

        // three-level tree streaming, true copies
        b_v = 1; b_m = 5'h1F; b_d = 4'h3;
        cyc();
        b_d = 4'hA;
        cyc();
        b_d = 4'h5;
        cyc();
        chk("t2_c3_valid", 32'(b_ov), 32'h1F);
        chk("t2_c3_data", 32'(b_od), 32'h33333);
        b_v = 0;
        cyc();
        chk("t2_c4_data", 32'(b_od), 32'hAAAAA);
        cyc();
        chk("t2_c5_data", 32'(b_od), 32'h55555);
        chk("t2_count", 32'(b_cnt), 32'd3);

        // counter saturation
        b_v = 1;
        repeat (10) cyc();
        b_v = 0;
        repeat (3) cyc();
        chk("t6_saturate", 32'(b_cnt), 32'd7);

        // randomized traffic with stalls on both trees
        for (int t = 0; t < 400; t++) begin
            a_v = 1'($urandom); a_d = 1'($urandom); a_m = 8'($urandom);
            a_s = ($urandom_range(0, 3) == 0);
            b_v = 1'($urandom); b_d = 4'($urandom); b_m = 5'($urandom);
            b_s = ($urandom_range(0, 3) == 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fanout_pipe_tree.md
Name: fanout_pipe_tree

Overview:
- Parametrised, pipelined fanout buffer tree: one WIDTH-bit source is distributed to NUM_SINKS registered sinks.
- No register drives more than MAX_FANOUT loads.
- Optional inversion at the leaves, per-sink enable masking, global stall, and a saturating transfer counter.
- Sits between a high-fanout driver and its sink cells; it is the sequential, fanout-bounded successor to the flat one-driver/many-inverter structure.

Parameters:
- WIDTH, 1, data bits per sink.
- NUM_SINKS, 8, number of leaf outputs (>=1).
- MAX_FANOUT, 4, maximum loads per tree register (>=2).
- INVERT, 1, 1 = leaf data is bitwise inverse of source; 0 = true copy.
- CNT_W, 16, width of the transfer counter.

Ports:
- iccad_clk  input  1  clock; all state on rising edge.
- iccad_rst  input  1  asynchronous, active-high reset.
- inp_valid  input  1  source data valid this cycle.
- inp_data  input  WIDTH  source data.
- sink_mask  input  NUM_SINKS  per-sink enable, sampled with inp_data.
- stall  input  1  global hold; freezes every register.
- out_valid  output  NUM_SINKS  per-sink valid.
- out_data  output  NUM_SINKS*WIDTH  sink i occupies bits [i*WIDTH +: WIDTH].
- xfer_count  output  CNT_W  cycles in which any out_valid bit was asserted, saturating.

Behaviour:
- LEVELS: the smallest L >= 1 with MAX_FANOUT^L >= NUM_SINKS. Computed by a constant function; elaboration error if NUM_SINKS < 1, MAX_FANOUT < 2 or LEVELS > 8.
- Level k (0..LEVELS-1) has n_k = ceil(NUM_SINKS / MAX_FANOUT^(LEVELS-1-k)) registers; the last level has exactly NUM_SINKS registers.
- Node j at level k+1 is fed from node floor(j/MAX_FANOUT) at level k. Level 0 nodes are fed directly from inp_data.
- Latency: exactly LEVELS cycles from inp_valid/inp_data/sink_mask to out_valid/out_data when stall is low throughout.
- Every tree node carries {valid, data}. sink_mask travels as a NUM_SINKS-bit shift pipeline of LEVELS stages, aligned with the data.
- Leaf stage, when stall is low and the arriving valid=1 with mask bit i=1:
  - out_valid[i] <= 1.
  - out_data[i] <= INVERT ? ~d : d.
- Leaf stage, when the arriving valid=0 or mask bit i=0:
  - out_valid[i] <= 0.
  - out_data[i] holds its previous value. This emulates a gated sink.
- Inversion is applied only at the leaves. Interior nodes store true data.
- stall=1: all tree, mask-pipe, valid and output registers and xfer_count hold. inp_* is ignored that cycle and is not captured later. No valid is dropped or duplicated inside the pipe.
- xfer_count:
  - Increments by 1 on each non-stalled edge where the next value of out_valid is non-zero.
  - Saturates at 2^CNT_W-1; no wrap.
- Reset (async assert, any time including mid-flight): every register goes to 0 immediately.
  - out_valid=0, out_data=0 (not inverted), xfer_count=0.
  - In-flight data is discarded.
- Reset release: the first capture happens on the first rising edge with iccad_rst low.
- NUM_SINKS=1: LEVELS=1, a single register, latency 1.
- A non-power-of-MAX_FANOUT NUM_SINKS leaves the last parent partially loaded; unused child slots are not generated.
- Back-to-back valids are accepted every cycle; throughput is 1 per cycle.

Test Plan:
- Defaults, reset, then inp_valid=1, inp_data=1, sink_mask=8'hFF for 1 cycle -> after exactly 2 cycles out_valid=8'hFF, all out_data bits 0. The next cycle gives out_valid=0 with data held; xfer_count=1.
- INVERT=0, WIDTH=4, NUM_SINKS=5, MAX_FANOUT=2 (LEVELS=3); stream 4'h3, 4'hA, 4'h5 on consecutive cycles, mask all ones -> the same values appear on all 5 sinks on cycles 3, 4 and 5; xfer_count=3.
- Defaults, first send data=0 with mask=8'hFF, then data=1 with mask=8'h0F -> sinks 0-3 show out_valid=1 and data 0 after the second send. Sinks 4-7 show out_valid=0 and keep data 1 from the first send.
- Send valid, then raise stall for 3 cycles at cycle 1 -> the output appears at cycle 5, not 2. Inputs applied during the stall are never emitted. xfer_count unchanged while stalled.
- Assert iccad_rst asynchronously mid-cycle with 2 transfers in flight -> outputs zero before the next edge; nothing emitted after release until new input arrives.
- CNT_W=3, continuous valids for 10 cycles -> xfer_count stops at 7.
